md_unit: RTL and testbench

- Parametrised multiply/divide unit with HI/LO registers for the EX stage of the pipelined MIPS core.
- Accepts one operation per start pulse and runs it for a fixed latency.
- Asserts busy while it runs; the hazard unit stalls any later HI/LO-touching instruction in ID on busy or start.
- Adds two things the current datapath lacks: multiply-accumulate ops, and a flush input so a cancelled instruction (exception or branch kill) never commits to HI/LO.

---
 rtl/md_unit_if.sv | 24 ++
 rtl/md_unit.sv | 163 ++++++++++++++++
 tb/tb_md_unit.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/md_unit_if.sv
// Bus between the EX stage and the HI/LO multiply/divide unit.
interface md_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output start, op, A, B, flush,
    input  busy, done, HI, LO
  );

  modport slave (
    input  start, op, A, B, flush,
    output busy, done, HI, LO
  );
endinterface

// File: rtl/md_unit.sv
// Fixed-latency multiply/divide unit with HI/LO registers, MAC ops and flush.
module md_unit #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic    clk,
  input  logic    reset,
  md_unit_if.slave bus
);

  localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
  localparam int unsigned PROD_W  = 2 * WIDTH;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic              is_signed;
  logic [PROD_W-1:0] a_ext, b_ext, prod, acc;
  logic              a_neg, b_neg, b_zero;
  logic [WIDTH-1:0]  a_mag, b_mag, divisor, q_mag, r_mag, quo, rem;

  // Datapath on latched operands: full-width product and sign-corrected division.
  always_comb begin
    is_signed = (op_q == OP_MULT) || (op_q == OP_DIV) ||
                (op_q == OP_MADD) || (op_q == OP_MSUB);
    a_ext     = is_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    b_ext     = is_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod      = a_ext * b_ext;
    acc       = {hi_q, lo_q};
    a_neg     = is_signed && a_q[WIDTH-1];
    b_neg     = is_signed && b_q[WIDTH-1];
    b_zero    = (b_q == '0);
    a_mag     = a_neg ? (~a_q + WIDTH'(1)) : a_q;
    b_mag     = b_neg ? (~b_q + WIDTH'(1)) : b_q;
    divisor   = b_zero ? WIDTH'(1) : b_mag;
    q_mag     = a_mag / divisor;
    r_mag     = a_mag % divisor;
    quo       = (a_neg ^ b_neg) ? (~q_mag + WIDTH'(1)) : q_mag;
    rem       = a_neg ? (~r_mag + WIDTH'(1)) : r_mag;
  end

  // Next-state and next-output logic for the IDLE/RUN sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    busy_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          case (bus.op)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
              op_d    = bus.op;
              a_d     = bus.A;
              b_d     = bus.B;
              cnt_d   = CNT_W'(MULT_LAT);
              state_d = S_RUN;
            end
            OP_DIV, OP_DIVU: begin
              op_d    = bus.op;
              a_d     = bus.A;
              b_d     = bus.B;
              cnt_d   = CNT_W'(DIV_LAT);
              state_d = S_RUN;
            end
            OP_MTHI: hi_d = bus.A;
            OP_MTLO: lo_d = bus.A;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (bus.flush) begin
          // Cancelled instruction: abandon without touching HI/LO.
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          case (op_q)
            OP_MULT, OP_MULTU:  {hi_d, lo_d} = prod;
            OP_MADD, OP_MADDU:  {hi_d, lo_d} = acc + prod;
            OP_MSUB, OP_MSUBU:  {hi_d, lo_d} = acc - prod;
            OP_DIV, OP_DIVU: begin
              // Divide by zero leaves HI/LO untouched but still completes.
              if (!b_zero) begin
                hi_d = rem;
                lo_d = quo;
              end
            end
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d == S_RUN);
  end

  // State, operand and HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit.
module tb_md_unit;
  localparam int unsigned WIDTH    = 32;
  localparam int unsigned MULT_LAT = 5;
  localparam int unsigned DIV_LAT  = 10;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MSUBU = 4'd9;

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  md_unit_if #(.WIDTH(WIDTH)) mif ();

  md_unit #(
    .WIDTH(WIDTH),
    .MULT_LAT(MULT_LAT),
    .DIV_LAT(DIV_LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(mif)
  );

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one start for a single cycle; returns at the negedge after the start edge.
  task automatic issue(input logic [3:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic fl);
    mif.start = 1'b1;
    mif.op    = op;
    mif.A     = a;
    mif.B     = b;
    mif.flush = fl;
    @(negedge clk);
    mif.start = 1'b0;
    mif.flush = 1'b0;
  endtask

  // Walk the run window checking busy, then check the done pulse and result.
  task automatic wait_commit(input string tag, input int lat,
                             input logic [WIDTH-1:0] exp_hi, input logic [WIDTH-1:0] exp_lo);
    for (int i = 0; i < lat; i++) begin
      chk({tag, "_busy_run"}, WIDTH'(mif.busy), WIDTH'(1));
      chk({tag, "_done_run"}, WIDTH'(mif.done), WIDTH'(0));
      @(negedge clk);
    end
    chk({tag, "_busy_end"}, WIDTH'(mif.busy), WIDTH'(0));
    chk({tag, "_done_end"}, WIDTH'(mif.done), WIDTH'(1));
    chk({tag, "_hi"}, mif.HI, exp_hi);
    chk({tag, "_lo"}, mif.LO, exp_lo);
  endtask

  task automatic settle(input string tag);
    @(negedge clk);
    chk({tag, "_done_clr"}, WIDTH'(mif.done), WIDTH'(0));
  endtask

  initial begin
    mif.start = 1'b0;
    mif.op    = 4'd0;
    mif.A     = '0;
    mif.B     = '0;
    mif.flush = 1'b0;
    reset     = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hi", mif.HI, 32'h0);
    chk("rst_lo", mif.LO, 32'h0);
    chk("rst_busy", WIDTH'(mif.busy), WIDTH'(0));
    chk("rst_done", WIDTH'(mif.done), WIDTH'(0));
    reset = 1'b1;
    @(negedge clk);

    // Signed and unsigned multiply of the same operands.
    issue(OP_MULT, 32'hFFFF_FFFF, 32'h2, 1'b0);
    wait_commit("mult", MULT_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    settle("mult");
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'h2, 1'b0);
    wait_commit("multu", MULT_LAT, 32'h0000_0001, 32'hFFFF_FFFE);
    settle("multu");

    // Signed divide, then the overflow corner.
    issue(OP_DIV, 32'hFFFF_FFF9, 32'h2, 1'b0);
    wait_commit("div", DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    settle("div");
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_commit("div_ovf", DIV_LAT, 32'h0, 32'h8000_0000);
    settle("div_ovf");

    // MTHI/MTLO land at the start edge without busy.
    issue(OP_MTHI, 32'h11, 32'h0, 1'b0);
    chk("mthi_hi", mif.HI, 32'h11);
    chk("mthi_busy", WIDTH'(mif.busy), WIDTH'(0));
    issue(OP_MTLO, 32'h22, 32'h0, 1'b0);
    chk("mtlo_lo", mif.LO, 32'h22);
    chk("mtlo_busy", WIDTH'(mif.busy), WIDTH'(0));

    // Unsigned divide by zero keeps HI/LO but still pulses done.
    issue(OP_DIVU, 32'h7, 32'h0, 1'b0);
    wait_commit("divu0", DIV_LAT, 32'h11, 32'h22);
    settle("divu0");

    // Reserved op code does nothing.
    issue(4'd12, 32'hABCD, 32'h1, 1'b0);
    chk("nop_busy", WIDTH'(mif.busy), WIDTH'(0));
    chk("nop_hi", mif.HI, 32'h11);
    chk("nop_lo", mif.LO, 32'h22);

    // Accumulate then subtract through zero.
    issue(OP_MTHI, 32'h0, 32'h0, 1'b0);
    issue(OP_MTLO, 32'h5, 32'h0, 1'b0);
    issue(OP_MADD, 32'h3, 32'h4, 1'b0);
    wait_commit("madd", MULT_LAT, 32'h0, 32'h11);
    settle("madd");
    issue(OP_MSUBU, 32'h12, 32'h1, 1'b0);
    wait_commit("msubu", MULT_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    settle("msubu");

    // Flush in run cycle 3 aborts with no commit.
    issue(OP_MULT, 32'h3, 32'h3, 1'b0);
    repeat (2) @(negedge clk);
    mif.flush = 1'b1;
    @(negedge clk);
    mif.flush = 1'b0;
    chk("flush_busy", WIDTH'(mif.busy), WIDTH'(0));
    chk("flush_done", WIDTH'(mif.done), WIDTH'(0));
    for (int i = 0; i < MULT_LAT; i++) begin
      @(negedge clk);
      chk("flush_nodone", WIDTH'(mif.done), WIDTH'(0));
    end
    chk("flush_hi", mif.HI, 32'hFFFF_FFFF);
    chk("flush_lo", mif.LO, 32'hFFFF_FFFF);

    // Flush on the commit edge also suppresses the write.
    issue(OP_MULT, 32'h3, 32'h3, 1'b0);
    repeat (MULT_LAT - 1) @(negedge clk);
    chk("flc_busy_pre", WIDTH'(mif.busy), WIDTH'(1));
    mif.flush = 1'b1;
    @(negedge clk);
    mif.flush = 1'b0;
    chk("flc_busy", WIDTH'(mif.busy), WIDTH'(0));
    chk("flc_done", WIDTH'(mif.done), WIDTH'(0));
    chk("flc_lo", mif.LO, 32'hFFFF_FFFF);

    // Flush alongside a start drops even MTHI.
    issue(OP_MTHI, 32'h1234, 32'h0, 1'b1);
    chk("sflush_hi", mif.HI, 32'hFFFF_FFFF);

    // MTHI while busy is ignored; async reset mid-divide aborts.
    issue(OP_DIV, 32'd100, 32'd7, 1'b0);
    repeat (3) @(negedge clk);
    mif.start = 1'b1;
    mif.op    = OP_MTHI;
    mif.A     = 32'hDEAD;
    @(negedge clk);
    mif.start = 1'b0;
    chk("busy_mthi_busy", WIDTH'(mif.busy), WIDTH'(1));
    chk("busy_mthi_hi", mif.HI, 32'hFFFF_FFFF);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("arst_hi", mif.HI, 32'h0);
    chk("arst_lo", mif.LO, 32'h0);
    chk("arst_busy", WIDTH'(mif.busy), WIDTH'(0));
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < DIV_LAT + 2; i++) begin
      @(negedge clk);
      chk("arst_nodone", WIDTH'(mif.done), WIDTH'(0));
    end
    chk("arst_hi_after", mif.HI, 32'h0);
    chk("arst_lo_after", mif.LO, 32'h0);

    // Back-to-back: second op launched in the done cycle.
    issue(OP_MULT, 32'h3, 32'h5, 1'b0);
    wait_commit("b2b_1", MULT_LAT, 32'h0, 32'hF);
    issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 1'b0);
    wait_commit("b2b_2", MULT_LAT - 1 + 1, 32'h1, 32'h0);
    settle("b2b_2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
